// File: rtl/datapath_scsi_packer.sv
// SCSI <-> FIFO width converter: packs SCSI beats into FIFO words (S2F) and
// unpacks FIFO words into SCSI beats (F2S), with partial-word flush and a
// saturating beat counter.
module datapath_scsi_packer #(
  parameter int SCSI_W     = 8,
  parameter int WORD_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_dir,
  input  logic                       i_flush,
  input  logic [SCSI_W-1:0]          i_scsi_data_in,
  input  logic                       i_scsi_in_vld,
  output logic                       o_scsi_in_rdy,
  output logic [SCSI_W-1:0]          o_scsi_data_out,
  output logic                       o_scsi_out_vld,
  input  logic                       i_scsi_out_rdy,
  output logic [WORD_W-1:0]          o_fifo_wd,
  output logic                       o_fifo_wr,
  output logic [WORD_W/SCSI_W-1:0]   o_fifo_be,
  input  logic                       i_fifo_full,
  output logic                       o_fifo_rd,
  input  logic [WORD_W-1:0]          i_fifo_od,
  input  logic                       i_fifo_empty,
  output logic [CNT_W-1:0]           o_beat_cnt,
  output logic                       o_busy
);

  localparam int LANES  = WORD_W / SCSI_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_RX_WR, S_RX_FL, S_TX_RD, S_TX_LD, S_TX_SH
  } state_t;

  state_t              r_state, w_next;
  logic [LANE_W-1:0]   r_lane;
  logic [WORD_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_flush_pend;   // FLUSH seen while a full word is still waiting to be written
  logic                w_last_lane;
  logic                w_in_acc;
  logic                w_out_acc;

  // Bit offset of a lane inside the word; lane 0 sits at the top in 68k order.
  function automatic int lane_off(input int lane);
    if (BIG_ENDIAN != 0) return (LANES - 1 - lane) * SCSI_W;
    return lane * SCSI_W;
  endfunction

  // Beat counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_last_lane = (int'(r_lane) == LANES - 1);
  assign w_in_acc    = (r_state == S_RX) && i_scsi_in_vld;
  assign w_out_acc   = (r_state == S_TX_SH) && i_scsi_out_rdy;
  assign o_beat_cnt  = r_cnt;
  assign o_busy      = (r_state != S_IDLE);

  // State register; reset drops any transfer in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    w_next          = r_state;
    o_scsi_in_rdy   = 1'b0;
    o_scsi_out_vld  = 1'b0;
    o_scsi_data_out = '0;
    o_fifo_wr       = 1'b0;
    o_fifo_wd       = '0;
    o_fifo_be       = '0;
    o_fifo_rd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = i_dir ? S_RX : S_TX_RD;
      end
      S_RX: begin
        o_scsi_in_rdy = 1'b1;
        // A beat accepted alongside FLUSH still lands in the word.
        if (w_in_acc && w_last_lane)                w_next = S_RX_WR;
        else if (i_flush && (r_lane == '0) && !w_in_acc) w_next = S_IDLE;
        else if (i_flush)                           w_next = S_RX_FL;
      end
      S_RX_WR: begin
        o_fifo_wr = ~i_fifo_full;
        o_fifo_wd = r_hold;
        o_fifo_be = '1;
        if (!i_fifo_full) w_next = (r_flush_pend || i_flush) ? S_IDLE : S_RX;
      end
      S_RX_FL: begin
        o_fifo_wr = ~i_fifo_full;
        // Unfilled lanes may hold stale data from an earlier word; force them to 0.
        for (int i = 0; i < LANES; i++) begin
          if (i < int'(r_lane)) begin
            o_fifo_wd[lane_off(i) +: SCSI_W] = r_hold[lane_off(i) +: SCSI_W];
            o_fifo_be[i] = 1'b1;
          end
        end
        if (!i_fifo_full) w_next = S_IDLE;
      end
      S_TX_RD: begin
        // No read is issued on an abort, so no FIFO word is consumed and lost.
        if (i_flush) w_next = S_IDLE;
        else if (!i_fifo_empty) begin
          o_fifo_rd = 1'b1;
          w_next    = S_TX_LD;
        end
      end
      S_TX_LD: begin
        w_next = i_flush ? S_IDLE : S_TX_SH;
      end
      S_TX_SH: begin
        o_scsi_out_vld  = 1'b1;
        o_scsi_data_out = r_hold[lane_off(int'(r_lane)) +: SCSI_W];
        if (i_flush)                   w_next = S_IDLE;
        else if (w_out_acc && w_last_lane) w_next = S_TX_RD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lane pointer, holding register, beat counter and pending-flush flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane       <= '0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt        <= '0;
            r_lane       <= '0;
            r_flush_pend <= 1'b0;
          end
        end
        S_RX: begin
          if (w_in_acc) begin
            r_hold[lane_off(int'(r_lane)) +: SCSI_W] <= i_scsi_data_in;
            r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
            r_cnt  <= sat_inc(r_cnt);
            if (i_flush && w_last_lane) r_flush_pend <= 1'b1;
          end
        end
        S_RX_WR: begin
          if (i_flush) r_flush_pend <= 1'b1;
        end
        S_RX_FL: begin
          if (!i_fifo_full) r_lane <= '0;
        end
        S_TX_LD: begin
          r_hold <= i_fifo_od;
          r_lane <= '0;
        end
        S_TX_SH: begin
          if (w_out_acc) begin
            r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
            r_cnt  <= sat_inc(r_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_scsi_packer.sv
// Scoreboard bench for datapath_scsi_packer: directed cases plus randomized
// S2F / F2S transfers checked against a word/byte-level reference model.
module tb_datapath_scsi_packer;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, dir = 1'b0, flush = 1'b0;
  logic [7:0]  din = '0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [7:0]  dout;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] fifo_wd;
  logic        fifo_wr;
  logic [3:0]  fifo_be;
  logic        fifo_full = 1'b0;
  logic        fifo_rd;
  logic [31:0] fifo_od = '0;
  logic        fifo_empty = 1'b1;
  logic [15:0] beat_cnt;
  logic        busy;

  // 16-bit little-endian instance
  logic        s_start = 1'b0, s_flush = 1'b0, s_vld = 1'b0;
  logic [15:0] s_din = '0;
  logic        s_in_rdy, s_out_vld, s_wr, s_rd, s_busy;
  logic [15:0] s_dout, s_cnt;
  logic [31:0] s_wd;
  logic [1:0]  s_be;

  always #5 clk = ~clk;

  datapath_scsi_packer #(.SCSI_W(8), .WORD_W(32), .BIG_ENDIAN(1), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir(dir), .i_flush(flush),
    .i_scsi_data_in(din), .i_scsi_in_vld(in_vld), .o_scsi_in_rdy(in_rdy),
    .o_scsi_data_out(dout), .o_scsi_out_vld(out_vld), .i_scsi_out_rdy(out_rdy),
    .o_fifo_wd(fifo_wd), .o_fifo_wr(fifo_wr), .o_fifo_be(fifo_be), .i_fifo_full(fifo_full),
    .o_fifo_rd(fifo_rd), .i_fifo_od(fifo_od), .i_fifo_empty(fifo_empty),
    .o_beat_cnt(beat_cnt), .o_busy(busy));

  datapath_scsi_packer #(.SCSI_W(16), .WORD_W(32), .BIG_ENDIAN(0), .CNT_W(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_dir(1'b1), .i_flush(s_flush),
    .i_scsi_data_in(s_din), .i_scsi_in_vld(s_vld), .o_scsi_in_rdy(s_in_rdy),
    .o_scsi_data_out(s_dout), .o_scsi_out_vld(s_out_vld), .i_scsi_out_rdy(1'b0),
    .o_fifo_wd(s_wd), .o_fifo_wr(s_wr), .o_fifo_be(s_be), .i_fifo_full(1'b0),
    .o_fifo_rd(s_rd), .i_fifo_od(32'h0), .i_fifo_empty(1'b1),
    .o_beat_cnt(s_cnt), .o_busy(s_busy));

  int checks = 0, errors = 0;
  int n_rd = 0, n_wr = 0;
  bit rand_mode = 1'b0;

  logic [31:0] exp_wd_q[$];
  logic [3:0]  exp_be_q[$];
  logic [7:0]  exp_b_q[$];
  logic [31:0] exp16_q[$];
  logic [31:0] src_q[$];
  logic [7:0]  bq[$];
  logic [31:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr && fifo_rd) chk("rd_wr_exclusive", 1, 0);
      if (fifo_wr) begin
        n_wr++;
        if (exp_wd_q.size() == 0) chk("fifo_wr_unexpected", fifo_wd, 0);
        else begin
          chk("fifo_wd", fifo_wd, exp_wd_q.pop_front());
          chk("fifo_be", fifo_be, exp_be_q.pop_front());
        end
      end
      if (out_vld && out_rdy) begin
        if (exp_b_q.size() == 0) chk("scsi_out_unexpected", dout, 0);
        else chk("scsi_data_out", dout, exp_b_q.pop_front());
      end
      if (!out_vld) chk("scsi_out_idle_zero", dout, 0);
      if (s_wr) begin
        if (exp16_q.size() == 0) chk("fifo16_wr_unexpected", s_wd, 0);
        else begin
          chk("fifo16_wd", s_wd, exp16_q.pop_front());
          chk("fifo16_be", s_be, 2'b11);
        end
      end
    end
  end

  // One clock: the bench also plays the FIFO read side and random back-pressure.
  task automatic tick();
    bit rd_now;
    @(negedge clk);
    rd_now = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_now) begin
      n_rd++;
      if (src_q.size() > 0) fifo_od = src_q.pop_front();
    end
    fifo_empty = (src_q.size() == 0);
    if (rand_mode) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      out_rdy   = ($urandom_range(0, 2) != 0);
    end
  endtask

  // Reference: beats fill lanes 0..3, lane 0 in the most significant byte.
  task automatic model_s2f();
    int k = 0;
    while (k < bq.size()) begin
      logic [31:0] w = 0;
      logic [3:0]  be = 0;
      for (int i = 0; i < L; i++)
        if (k + i < bq.size()) begin
          w  = w | (32'(bq[k + i]) << (8 * (L - 1 - i)));
          be = be | 4'(1 << i);
        end
      exp_wd_q.push_back(w);
      exp_be_q.push_back(be);
      k += L;
    end
  endtask

  task automatic send_beat(input logic [7:0] b);
    int n = 0;
    if (rand_mode) repeat ($urandom_range(0, 2)) tick();
    in_vld = 1'b1;
    din    = b;
    while (!in_rdy && n < 200) begin tick(); n++; end
    if (n >= 200) chk("in_rdy_timeout", 0, 1);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  task automatic run_s2f();
    model_s2f();
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    chk("s2f_busy", busy, 1);
    foreach (bq[i]) send_beat(bq[i]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("s2f_idle");
    chk("s2f_beat_cnt", beat_cnt, bq.size());
    chk("s2f_all_words", exp_wd_q.size(), 0);
  endtask

  task automatic run_f2s();
    int rd0 = n_rd;
    int n = 0;
    foreach (wq[j]) begin
      src_q.push_back(wq[j]);
      for (int i = 0; i < L; i++) exp_b_q.push_back(8'(wq[j] >> (8 * (L - 1 - i))));
    end
    tick();
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    while (exp_b_q.size() != 0 && n < 400) begin tick(); n++; end
    chk("f2s_beats_done", exp_b_q.size(), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f2s_idle", busy, 0);
    chk("f2s_beat_cnt", beat_cnt, wq.size() * L);
    chk("f2s_fifo_reads", n_rd - rd0, wq.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, n;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_fifo_be", fifo_be, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // T1: full word, big-endian
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr0 = n_wr;
    run_s2f();
    chk("t1_one_write", n_wr - wr0, 1);

    // T2: partial word flush
    bq = '{8'hAA, 8'hBB};
    run_s2f();

    // T3: unpack one word with SCSI side always ready
    out_rdy = 1'b1;
    wq = '{32'hDEADBEEF};
    run_f2s();

    // T5: FULL held five cycles at the word write
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_s2f();
    wr0 = n_wr;
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    foreach (bq[i]) send_beat(bq[i]);
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t5_in_rdy_stall", in_rdy, 0);
      chk("t5_fifo_wr_stall", fifo_wr, 0);
      tick();
    end
    fifo_full = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t5_idle");
    chk("t5_single_write", n_wr - wr0, 1);

    // T6: reset during the third outbound beat
    src_q.push_back(32'hCAFEF00D);
    exp_b_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    tick();
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (beat_cnt != 2 && n < 50) begin tick(); n++; end
    chk("t6_reach_lane2", beat_cnt, 2);
    rst = 1'b1;
    #1;
    chk("t6_out_vld", out_vld, 0);
    chk("t6_dout", dout, 0);
    chk("t6_busy", busy, 0);
    chk("t6_beat_cnt", beat_cnt, 0);
    chk("t6_fifo_rd", fifo_rd, 0);
    chk("t6_fifo_wr", fifo_wr, 0);
    exp_b_q.delete();
    src_q.delete();
    tick();
    rst = 1'b0;
    tick();
    wq = '{32'h0123ABCD};
    run_f2s();

    // T4: 16-bit little-endian packing
    exp16_q.push_back(32'h56781234);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_vld = 1'b1; s_din = 16'h1234;
    tick();
    s_din = 16'h5678;
    tick();
    s_vld = 1'b0;
    tick();
    chk("t4_beat_cnt", s_cnt, 2);
    chk("t4_word_written", exp16_q.size(), 0);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk("t4_idle", s_busy, 0);

    // Randomized transfers with back-pressure on both sides
    rand_mode = 1'b1;
    for (int it = 0; it < 10; it++) begin
      bq.delete();
      repeat ($urandom_range(1, 11)) bq.push_back(8'($urandom));
      run_s2f();
      wq.delete();
      repeat ($urandom_range(1, 3)) wq.push_back($urandom);
      run_f2s();
    end
    rand_mode = 1'b0;
    fifo_full = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
